// File: rtl/komandara_wrr_arbiter_if.sv
// Request/grant bundle between the requesters and the weighted round-robin arbiter.
// master = requester side, slave = arbiter side.
interface komandara_wrr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req_i;
  logic             advance_i;
  logic [N_REQ-1:0] gnt_o;
  logic [IDX_W-1:0] gnt_idx_o;
  logic             valid_o;
  logic [N_REQ-1:0] starve_o;

  modport master (
    output req_i, advance_i,
    input  gnt_o, gnt_idx_o, valid_o, starve_o
  );

  modport slave (
    input  req_i, advance_i,
    output gnt_o, gnt_idx_o, valid_o, starve_o
  );
endinterface

// File: rtl/komandara_wrr_arbiter.sv
// Weighted round-robin arbiter: the grant is held for a whole transaction until advance_i,
// each owner gets up to WEIGHT back-to-back grants, and long waiters are pulled to the front.
module komandara_wrr_arbiter #(
  parameter int                      N_REQ        = 4,
  parameter int                      CRED_W       = 4,
  parameter logic [N_REQ*CRED_W-1:0] WEIGHTS      = {N_REQ{{(CRED_W-1){1'b0}}, 1'b1}},
  parameter int                      STARVE_LIMIT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  komandara_wrr_arbiter_if.slave bus
);
  localparam int                  IDX_W    = $clog2(N_REQ);
  localparam int                  WAIT_W   = (STARVE_LIMIT > 32'sd0) ? $clog2(STARVE_LIMIT + 32'sd1) : 32'sd1;
  localparam logic [WAIT_W-1:0]   WAIT_MAX = WAIT_W'(STARVE_LIMIT);
  localparam logic                AGING_EN = (STARVE_LIMIT != 32'sd0);
  localparam logic [N_REQ-1:0]    ONEHOT0  = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [0:0]          ST_IDLE  = 1'b0;
  localparam logic [0:0]          ST_BUSY  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CRED_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q [N_REQ];
  logic [WAIT_W-1:0] wait_d [N_REQ];
  logic [N_REQ-1:0]  urgent_s, starve_s;
  logic [IDX_W-1:0]  win_s;
  logic              reload_s, grant_s;
  int                cand_s;

  function automatic logic [CRED_W-1:0] weight_of(input logic [IDX_W-1:0] idx);
    logic [CRED_W-1:0] w;
    w = WEIGHTS[int'(idx)*CRED_W +: CRED_W];
    return (w == '0) ? CRED_W'(1'b1) : w;
  endfunction

  // Requesters whose wait counter has saturated at the aging limit.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      starve_s[i] = AGING_EN && (wait_q[i] == WAIT_MAX);
      urgent_s[i] = starve_s[i] && bus.req_i[i];
    end
  end

  // Winner: lowest urgent index, else continue ptr while it has credit, else rotate from ptr+1.
  always_comb begin
    win_s    = ptr_q;
    reload_s = 1'b0;
    cand_s   = 0;
    if (|urgent_s) begin
      reload_s = 1'b1;
      for (int i = N_REQ - 1; i >= 0; i--) begin
        win_s = urgent_s[i] ? IDX_W'(i) : win_s;
      end
    end else if (bus.req_i[ptr_q] && (cnt_q != '0)) begin
      win_s    = ptr_q;
      reload_s = 1'b0;
    end else begin
      reload_s = 1'b1;
      // Walk backwards so the nearest requester after ptr is written last.
      for (int k = N_REQ; k >= 1; k--) begin
        cand_s = (int'(ptr_q) + k >= N_REQ) ? int'(ptr_q) + k - N_REQ : int'(ptr_q) + k;
        win_s  = bus.req_i[IDX_W'(cand_s)] ? IDX_W'(cand_s) : win_s;
      end
    end
  end

  // Grant FSM next state: arbitrate in IDLE, hold in BUSY until the owner releases.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_i) begin
          grant_s   = 1'b1;
          state_d   = ST_BUSY;
          gnt_d     = ONEHOT0 << win_s;
          gnt_idx_d = win_s;
          ptr_d     = win_s;
          cnt_d     = reload_s ? weight_of(win_s) : cnt_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.advance_i) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = (cnt_q != '0) ? cnt_q - CRED_W'(1'b1) : cnt_q;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Wait counters: clear on being granted or not requesting, else count up to the limit.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s && (win_s == IDX_W'(i))) begin
        wait_d[i] = '0;
      end else if (bus.req_i[i] && !gnt_q[i]) begin
        wait_d[i] = (wait_q[i] == WAIT_MAX) ? wait_q[i] : wait_q[i] + WAIT_W'(1'b1);
      end else begin
        wait_d[i] = '0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      ptr_q     <= IDX_W'(N_REQ - 1);
      cnt_q     <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < N_REQ; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_idx_o = gnt_idx_q;
  assign bus.valid_o   = (state_q == ST_BUSY);
  assign bus.starve_o  = starve_s;
endmodule

// File: tb/tb_komandara_wrr_arbiter.sv
// Bench for komandara_wrr_arbiter: two configurations checked every cycle against a
// behavioural model, plus directed grant-sequence scenarios and randomized traffic.
module tb_komandara_wrr_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  komandara_wrr_arbiter_if #(.N_REQ(4)) if_a ();
  komandara_wrr_arbiter_if #(.N_REQ(4)) if_b ();

  komandara_wrr_arbiter #(.N_REQ(4), .CRED_W(4), .WEIGHTS(16'h2311), .STARVE_LIMIT(0))
    dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a.slave));
  komandara_wrr_arbiter #(.N_REQ(4), .CRED_W(4), .WEIGHTS(16'h103F), .STARVE_LIMIT(4))
    dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b.slave));

  logic [3:0] req [2];
  logic       adv [2];
  assign if_a.req_i = req[0];  assign if_a.advance_i = adv[0];
  assign if_b.req_i = req[1];  assign if_b.advance_i = adv[1];

  logic [3:0] gnt_w [2];  logic [1:0] idx_w [2];  logic valid_w [2];  logic [3:0] starve_w [2];
  assign gnt_w[0] = if_a.gnt_o;  assign idx_w[0] = if_a.gnt_idx_o;
  assign valid_w[0] = if_a.valid_o;  assign starve_w[0] = if_a.starve_o;
  assign gnt_w[1] = if_b.gnt_o;  assign idx_w[1] = if_b.gnt_idx_o;
  assign valid_w[1] = if_b.valid_o;  assign starve_w[1] = if_b.starve_o;

  // Configuration as the model sees it: raw weights w0..w3 and the aging limit.
  int wraw [2][4] = '{'{1, 1, 3, 2}, '{15, 3, 0, 1}};
  int lim  [2]    = '{0, 4};

  // Model state: owner flag, owner index, pointer, credit, per-requester wait cycles.
  bit m_busy [2];
  int m_idx [2], m_ptr [2], m_cnt [2];
  int m_wait [2][4];

  int n_chk = 0, n_fail = 0;
  int g_n;
  int g_idx [16];
  logic [3:0] g_sb [16], g_sa [16];
  int exp_rot [9] = '{0, 1, 2, 2, 2, 3, 3, 0, 1};
  logic [3:0] exp_g, exp_s;
  int hold_bad;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int wt(input int d, input int i);
    return (wraw[d][i] == 0) ? 1 : wraw[d][i];
  endfunction

  task automatic model_reset(input int d);
    m_busy[d] = 1'b0; m_idx[d] = 0; m_ptr[d] = 3; m_cnt[d] = 0;
    for (int i = 0; i < 4; i++) m_wait[d][i] = 0;
  endtask

  task automatic model_step(input int d);
    logic [3:0] r;
    bit grant;
    int w, p;
    r = req[d];
    grant = !m_busy[d] && (r != 4'b0000);
    w = -1;
    if (grant) begin
      if (lim[d] != 0)
        for (int i = 0; i < 4; i++)
          if (w < 0 && r[i] && m_wait[d][i] == lim[d]) w = i;
      if (w >= 0) begin
        m_ptr[d] = w; m_cnt[d] = wt(d, w);
      end else if (r[m_ptr[d]] && m_cnt[d] > 0) begin
        w = m_ptr[d];
      end else begin
        for (int k = 1; k <= 4; k++) begin
          p = (m_ptr[d] + k) % 4;
          if (w < 0 && r[p]) w = p;
        end
        m_ptr[d] = w; m_cnt[d] = wt(d, w);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (grant && w == i) m_wait[d][i] = 0;
      else if (r[i] && !(m_busy[d] && m_idx[d] == i))
        m_wait[d][i] = (m_wait[d][i] + 1 > lim[d]) ? lim[d] : m_wait[d][i] + 1;
      else m_wait[d][i] = 0;
    end
    if (grant) begin
      m_busy[d] = 1'b1; m_idx[d] = w;
    end else if (m_busy[d] && adv[d]) begin
      m_busy[d] = 1'b0;
      m_cnt[d] = (m_cnt[d] > 0) ? m_cnt[d] - 1 : 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) model_reset(d);
    end else begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  // Per-cycle comparison of both DUTs against the model, plus output invariants.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_g = m_busy[d] ? (4'b0001 << m_idx[d]) : 4'b0000;
      for (int i = 0; i < 4; i++) exp_s[i] = (lim[d] != 0) && (m_wait[d][i] == lim[d]);
      chk($sformatf("gnt_o[dut%0d]", d), int'(gnt_w[d]), int'(exp_g));
      chk($sformatf("gnt_idx_o[dut%0d]", d), int'(idx_w[d]), m_idx[d]);
      chk($sformatf("valid_o[dut%0d]", d), int'(valid_w[d]), int'(m_busy[d]));
      chk($sformatf("starve_o[dut%0d]", d), int'(starve_w[d]), int'(exp_s));
      chk($sformatf("onehot[dut%0d]", d), int'($countones(gnt_w[d]) <= 1), 1);
      chk($sformatf("valid_vs_gnt[dut%0d]", d), int'(valid_w[d]), int'(|gnt_w[d]));
      if (valid_w[d]) chk($sformatf("gnt_at_idx[dut%0d]", d), int'(gnt_w[d][idx_w[d]]), 1);
    end
  end

  // Drive reqv, pulse advance in each BUSY cycle and record up to n_want grants.
  task automatic run_grants(input int d, input logic [3:0] reqv, input int n_want);
    int last;
    logic [3:0] st_prev;
    last = 0; g_n = 0; st_prev = starve_w[d]; req[d] = reqv;
    for (int c = 0; c < 4 * n_want + 8 && g_n < n_want; c++) begin
      @(negedge clk);
      if (valid_w[d]) begin
        g_idx[g_n] = int'(idx_w[d]); g_sb[g_n] = st_prev; g_sa[g_n] = starve_w[d];
        if (g_n > 0) chk("grant_spacing", c - last, 2);
        last = c; g_n++; adv[d] = 1'b1;
      end else begin
        adv[d] = 1'b0;
      end
      st_prev = starve_w[d];
    end
    @(negedge clk);
    adv[d] = 1'b0; req[d] = 4'b0000;
    chk("grant_count", g_n, n_want);
  endtask

  initial begin
    rst = 1'b1; req[0] = 4'hF; req[1] = 4'hF; adv[0] = 1'b0; adv[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt_w[0]), 0);
    chk("rst_valid", int'(valid_w[0]), 0);
    chk("rst_idx", int'(idx_w[0]), 0);
    chk("rst_starve", int'(starve_w[1]), 0);
    req[0] = 4'b0000; req[1] = 4'b0000; rst = 1'b0;
    @(negedge clk);

    // Weighted rotation on dut_a (w = 1,1,3,2, no aging).
    run_grants(0, 4'hF, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("rotation[%0d]", i), g_idx[i], exp_rot[i]);

    // Grant held for 100 cycles after a one-cycle request.
    req[0] = 4'b0001;
    @(negedge clk);
    req[0] = 4'b0000; hold_bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (gnt_w[0] != 4'b0001 || !valid_w[0]) hold_bad++;
    end
    chk("hold_cycles_bad", hold_bad, 0);
    adv[0] = 1'b1;
    @(negedge clk);
    adv[0] = 1'b0;
    chk("hold_release", int'(gnt_w[0]), 0);

    // Credit survives advance pulses in IDLE: requester 2 continues afterwards.
    run_grants(0, 4'b0100, 1);
    chk("idle_adv_first", g_idx[0], 2);
    adv[0] = 1'b1;
    repeat (3) @(negedge clk);
    adv[0] = 1'b0;
    chk("idle_adv_valid", int'(valid_w[0]), 0);
    run_grants(0, 4'hF, 1);
    chk("idle_adv_continue", g_idx[0], 2);

    // Forfeit: 2 drops, 0 wins, then 2 returns with a fresh credit of 3.
    run_grants(0, 4'b0001, 1);
    chk("forfeit_0", g_idx[0], 0);
    run_grants(0, 4'b0101, 4);
    chk("reload_0", g_idx[0], 2); chk("reload_1", g_idx[1], 2);
    chk("reload_2", g_idx[2], 2); chk("reload_3", g_idx[3], 0);

    // Reset mid-BUSY drops the grant at once; first grant afterwards is index 0.
    req[0] = 4'hF;
    @(negedge clk);
    chk("busy_before_rst", int'(valid_w[0]), 1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_busy_gnt", int'(gnt_w[0]), 0);
    @(negedge clk);
    rst = 1'b0; req[0] = 4'b0000;
    run_grants(0, 4'hF, 1);
    chk("after_rst_grant", g_idx[0], 0);

    // Starvation on dut_b (limit 4, w0 = 15): grants 0,0 then urgent 1.
    run_grants(1, 4'b0011, 3);
    chk("starve_g0", g_idx[0], 0); chk("starve_g1", g_idx[1], 0); chk("starve_g2", g_idx[2], 1);
    chk("starve_flag_before_g1", int'(g_sb[1][1]), 0);
    chk("starve_flag_before_g2", int'(g_sb[2][1]), 1);
    chk("starve_flag_cleared", int'(g_sa[2][1]), 0);

    // Zero weight on requester 2 behaves as one grant, then rotation to 1.
    run_grants(1, 4'b0100, 1);
    chk("zero_w_first", g_idx[0], 2);
    run_grants(1, 4'b0110, 2);
    chk("zero_w_next0", g_idx[0], 1); chk("zero_w_next1", g_idx[1], 1);

    // Randomized traffic on both configurations with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 3) == 0) req[d] = 4'($urandom_range(0, 15));
        adv[d] = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/komandara_wrr_arbiter.md
Name: komandara_wrr_arbiter

Overview:
- Weighted round-robin arbiter with grant hold and starvation aging. Shares a single downstream resource (one AXI4-Lite crossbar slave channel, or a shared bus port) between N_REQ requesters.
- Grant is registered and held for a whole transaction until the owner releases it with advance_i.
- Each requester gets up to WEIGHT consecutive grants before the round-robin pointer moves on.
- A requester that has waited STARVE_LIMIT cycles is forced to the front.

Parameters:
- N_REQ, 4: number of requesters (>=2).
- CRED_W, 4: width of each weight and credit counter.
- WEIGHTS, all fields 1: flat packed weights. Weight of requester i is WEIGHTS[i*CRED_W +: CRED_W]. A field value of 0 is treated as 1.
- STARVE_LIMIT, 15: wait cycles before a requester becomes urgent. 0 disables aging. Wait counters are $clog2(STARVE_LIMIT+1) bits, minimum 1.
- IDX_W (localparam): $clog2(N_REQ).

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset, asynchronous, active-high.
- req_i, in, N_REQ: request vector, one bit per requester.
- advance_i, in, 1: release pulse from the owner (e.g. B/R handshake done). Sampled only in BUSY.
- gnt_o, out, N_REQ: registered one-hot grant. All zero in IDLE.
- gnt_idx_o, out, IDX_W: registered binary index of the owner. Holds its last value in IDLE.
- valid_o, out, 1: high when state is BUSY (gnt_o nonzero).
- starve_o, out, N_REQ: bit i high while wait_cnt[i] == STARVE_LIMIT (forced 0 if STARVE_LIMIT == 0).

Behaviour:
- Internal state: FSM {IDLE, BUSY}; pointer ptr (IDX_W); credit cnt (CRED_W) belonging to ptr; wait_cnt[i] per requester.
- Reset (asynchronous, while rst_i = 1):
  - state = IDLE, gnt_o = 0, gnt_idx_o = 0, valid_o = 0, starve_o = 0.
  - ptr = N_REQ-1, cnt = 0, all wait_cnt = 0.
  - Reset asserted mid-BUSY drops the grant immediately; no advance is needed afterwards.
- IDLE with req_i == 0: no change.
- IDLE with req_i != 0: the winner W is selected combinationally and registered, so grant latency is 1 cycle. Next cycle: BUSY, gnt_o = onehot(W), gnt_idx_o = W. Selection priority:
  1. Urgent: any requesting i with wait_cnt[i] == STARVE_LIMIT (aging enabled). W = lowest-index urgent requester; ptr <= W; cnt <= weight(W).
  2. Continuation: req_i[ptr] && cnt > 0. W = ptr; ptr and cnt unchanged.
  3. Rotation: search from ptr+1, modulo N_REQ, for the first requester with req_i set. W = that requester; ptr <= W; cnt <= weight(W). Credit left over by an old ptr that is no longer requesting is forfeited.
- BUSY:
  - gnt_o, gnt_idx_o and ptr are held regardless of req_i. Dropping the request does not release the grant.
  - advance_i = 1: next cycle state = IDLE, gnt_o = 0, cnt <= cnt-1 (saturating at 0).
  - advance_i = 0: stay in BUSY.
- Minimum spacing between grants is 2 cycles (one mandatory IDLE cycle). advance_i in IDLE is ignored.
- Wait counters, every cycle:
  - Clear wait_cnt[i] on the IDLE→BUSY transition that grants i.
  - Else increment when req_i[i] && !gnt_o[i], saturating at STARVE_LIMIT.
  - Else (req_i[i] = 0) clear.
- A credit count of 0 for ptr forces rotation, or an urgent pick if one exists.
- Simultaneous urgent requesters: lowest index wins. The others stay saturated and win on subsequent arbitrations.
- With a single requester and any weight, it is re-granted every 2 cycles. Rotation wraps back to itself.
- Invariants (assertions): gnt_o is one-hot or zero; valid_o == |gnt_o; gnt_o[gnt_idx_o] == 1 whenever valid_o = 1.

Test Plan:
- Reset: hold rst_i = 1 with req_i = 4'hF -> gnt_o = 0, valid_o = 0, gnt_idx_o = 0, starve_o = 0. Assert rst_i mid-BUSY -> gnt_o = 0 within the same cycle; first grant after release goes to index 0.
- Weighted rotation: WEIGHTS w0=1, w1=1, w2=3, w3=2; STARVE_LIMIT = 0; req_i = 4'hF held; advance_i pulsed 1 cycle after each grant -> gnt_idx_o sequence 0,1,2,2,2,3,3,0,1, with grants every 2 cycles.
- Hold: req_i = 4'b0001 for 1 cycle, advance_i = 0 for 100 cycles -> gnt_o = 4'b0001 and valid_o = 1 throughout. One advance_i pulse -> gnt_o = 0 next cycle.
- Starvation: STARVE_LIMIT = 4, w0 = 15, req_i = 4'b0011 held, advance pulsed in each BUSY cycle -> grants 0, 0, then 1. starve_o[1] = 1 in the cycle before the third grant; wait_cnt[1] clears on that grant.
- Forfeit / zero weight: w0 = 0 (treated as 1), w1 = 3. req1 granted once, then req1 drops and req0 is requested -> grant 0. Reassert req1 -> grant 1 with cnt reloaded to 3, giving 3 consecutive grants to 1 while both request.
- advance_i asserted while IDLE with req_i = 0 -> no state change, cnt unchanged.
